// File: rtl/xor_encrypter_pipe.sv
// xor_encrypter_pipe: keyed rotate-XOR encrypter with one stage register and an output FIFO
module xor_encrypter_pipe #(
  parameter int WIDTH      = 8,
  parameter int ROT_W      = $clog2(WIDTH),
  parameter int FIFO_DEPTH = 4,
  parameter bit ROT_LEFT   = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [WIDTH-1:0]            data_in_p,
  input  logic [ROT_W-1:0]            key_rotation_p,
  input  logic                        prog_p,
  input  logic                        data_ready_in_p,
  output logic                        ready_p,
  output logic [WIDTH-1:0]            data_out_c,
  output logic                        data_ready_out_c,
  input  logic                        capture_c,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        key_loaded
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_C = (PW+2)'(FIFO_DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] key, s1_data, s1_key, cipher;
  logic [ROT_W-1:0] s1_off;
  logic [2*WIDTH-1:0] key2, rot2;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW+1:0] credit;
  logic s1_valid, accept, pop;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE && prog_p) ? RUN : state;
  end
  assign key_loaded = (state == RUN);
  // a pop in the same cycle is deliberately not counted as a free slot
  assign credit  = {1'b0, fifo_count} + (PW+2)'(s1_valid);
  assign ready_p = (state == RUN) && !prog_p && (credit < DEPTH_C);
  assign accept  = data_ready_in_p && ready_p;
  assign pop     = capture_c && data_ready_out_c;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) key <= '0;
    else if (prog_p) key <= data_in_p;
  // each word carries its own key snapshot so a reload cannot touch it
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_key   <= '0;
      s1_off   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= data_in_p;
        s1_key  <= key;
        s1_off  <= ROT_W'(32'(key_rotation_p) % WIDTH);
      end
    end
  // rotating a doubled key avoids any shift by the full width
  assign key2   = {s1_key, s1_key};
  assign rot2   = ROT_LEFT ? key2 << s1_off : key2 >> s1_off;
  assign cipher = s1_data ^ (ROT_LEFT ? rot2[2*WIDTH-1:WIDTH] : rot2[WIDTH-1:0]);
  always_ff @(posedge clk)
    if (s1_valid) mem[wr_ptr] <= cipher;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (s1_valid) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + (PW+1)'(s1_valid) - (PW+1)'(pop);
    end
  assign data_ready_out_c = (fifo_count != '0);
  assign data_out_c       = data_ready_out_c ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_xor_encrypter_pipe.sv
// tb_xor_encrypter_pipe: directed vectors, expected ciphertext queued at accept, checked at output
module tb_xor_encrypter_pipe;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] data_in_p = '0;
  logic [2:0] key_rotation_p = '0;
  logic prog_p = 1'b0;
  logic data_ready_in_p = 1'b0;
  logic ready_p;
  logic [7:0] data_out_c;
  logic data_ready_out_c;
  logic capture_c = 1'b0;
  logic [2:0] fifo_count;
  logic key_loaded;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  time t0;

  xor_encrypter_pipe dut (
    .clk(clk), .reset_n(reset_n), .data_in_p(data_in_p), .key_rotation_p(key_rotation_p),
    .prog_p(prog_p), .data_ready_in_p(data_ready_in_p), .ready_p(ready_p),
    .data_out_c(data_out_c), .data_ready_out_c(data_ready_out_c), .capture_c(capture_c),
    .fifo_count(fifo_count), .key_loaded(key_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n && data_ready_out_c && capture_c) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", data_out_c);
      end else chk("data_out_c", 32'(data_out_c), 32'(exp_q.pop_front()));
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] r, input logic [7:0] e);
    int n = 0;
    data_in_p = d;
    key_rotation_p = r;
    data_ready_in_p = 1'b1;
    @(negedge clk);
    while (!ready_p && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready_p) exp_q.push_back(e);
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: word %0h never accepted, expected acceptance", d);
    end
    tick();
    data_ready_in_p = 1'b0;
  endtask

  task automatic prog(input logic [7:0] k);
    data_in_p = k;
    prog_p = 1'b1;
    tick();
    prog_p = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || data_ready_out_c) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_ready", 32'(ready_p), 0);
    chk("rst_dout", 32'(data_out_c), 0);
    chk("rst_valid", 32'(data_ready_out_c), 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_keyld", 32'(key_loaded), 0);
    tick();
    reset_n = 1'b1;
    // words offered before any key must be ignored
    data_in_p = 8'h55;
    data_ready_in_p = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("idle_ready", 32'(ready_p), 0);
    data_ready_in_p = 1'b0;
    repeat (2) tick();
    chk("idle_count", 32'(fifo_count), 0);
    chk("idle_valid", 32'(data_ready_out_c), 0);
    prog(8'hA5);
    chk("keyld", 32'(key_loaded), 1);
    // latency: accept at edge N, visible after edge N+1
    data_in_p = 8'h0F;
    key_rotation_p = 3'd1;
    data_ready_in_p = 1'b1;
    @(negedge clk);
    chk("t1_ready", 32'(ready_p), 1);
    exp_q.push_back(8'h44);
    tick();
    data_ready_in_p = 1'b0;
    chk("t1_valid_n", 32'(data_ready_out_c), 0);
    tick();
    chk("t1_valid_n1", 32'(data_ready_out_c), 1);
    chk("t1_dout", 32'(data_out_c), 'h44);
    capture_c = 1'b1;
    tick();
    capture_c = 1'b0;
    chk("t1_valid_drop", 32'(data_ready_out_c), 0);
    chk("t1_count", 32'(fifo_count), 0);
    capture_c = 1'b1;
    send(8'h00, 3'd0, 8'hA5);
    send(8'hFF, 3'd7, 8'h2D);
    drain();
    // backpressure: four words fit, the rest wait
    capture_c = 1'b0;
    send(8'h01, 3'd2, 8'h97);
    send(8'h02, 3'd3, 8'h2F);
    send(8'h03, 3'd4, 8'h59);
    send(8'h04, 3'd5, 8'hB0);
    fork
      begin
        send(8'h05, 3'd6, 8'h6C);
        send(8'h06, 3'd0, 8'hA3);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready", 32'(ready_p), 0);
        chk("bp_count", 32'(fifo_count), 4);
        capture_c = 1'b1;
      end
    join
    drain();
    // streaming with the collector keeping up
    t0 = $time;
    fork
      begin
        send(8'h10, 3'd0, 8'hB5);
        send(8'h11, 3'd1, 8'h5A);
        send(8'h12, 3'd2, 8'h84);
        send(8'h13, 3'd3, 8'h3E);
        send(8'h14, 3'd4, 8'h4E);
        send(8'h15, 3'd5, 8'hA1);
        send(8'h16, 3'd6, 8'h7F);
        send(8'h17, 3'd7, 8'hC5);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("stream_count", 32'(fifo_count), 1);
      end
    join
    chk("stream_cycles", 32'(($time - t0) / 10), 8);
    drain();
    // key reload with words in flight
    capture_c = 1'b0;
    send(8'h20, 3'd1, 8'h6B);
    send(8'h21, 3'd0, 8'h84);
    data_in_p = 8'h3C;
    prog_p = 1'b1;
    data_ready_in_p = 1'b1;
    @(negedge clk);
    chk("prog_ready", 32'(ready_p), 0);
    tick();
    prog_p = 1'b0;
    data_ready_in_p = 1'b0;
    chk("prog_count", 32'(fifo_count), 2);
    tick();
    chk("prog_count2", 32'(fifo_count), 2);
    send(8'h22, 3'd1, 8'h5A);
    send(8'h23, 3'd4, 8'hE0);
    capture_c = 1'b1;
    drain();
    // asynchronous reset with buffered words
    capture_c = 1'b0;
    send(8'h30, 3'd0, 8'h0C);
    send(8'h31, 3'd1, 8'h49);
    send(8'h32, 3'd2, 8'hC2);
    repeat (2) tick();
    chk("pre_rst_count", 32'(fifo_count), 3);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(data_ready_out_c), 0);
    chk("arst_dout", 32'(data_out_c), 0);
    chk("arst_count", 32'(fifo_count), 0);
    chk("arst_ready", 32'(ready_p), 0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_keyld", 32'(key_loaded), 0);
    chk("post_rst_ready", 32'(ready_p), 0);
    data_in_p = 8'h77;
    data_ready_in_p = 1'b1;
    repeat (3) tick();
    data_ready_in_p = 1'b0;
    repeat (2) tick();
    chk("post_rst_count", 32'(fifo_count), 0);
    prog(8'hA5);
    capture_c = 1'b1;
    send(8'h0F, 3'd1, 8'h44);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
